sfx_sample_sequencer: RTL

- Sound-effect source stage that sits directly upstream of the I2S serializer.
- Accepts game-event triggers for the jump and death effects and reads 16-bit PCM samples from the external effect ROMs.
- Applies a volume attenuation and delivers exactly one sample per audio frame tick over a valid/ready handshake.
- Replaces ad-hoc address counting in the serializer; the serializer only consumes samples.

---
 rtl/sfx_sample_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/sfx_sample_sequencer.sv
// sfx_sample_sequencer: plays jump/death effect ROMs into the I2S serializer, one attenuated sample per frame tick
module sfx_sample_sequencer #(
  parameter int JUMP_LEN = 4096,
  parameter int DEAD_LEN = 16384,
  parameter int JUMP_AW = 12,
  parameter int DEAD_AW = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic               play_jump,
  input  logic               play_dead,
  input  logic               stop,
  input  logic [1:0]         volume,
  output logic [JUMP_AW-1:0] jump_addr,
  input  logic [15:0]        jump_data,
  output logic [DEAD_AW-1:0] dead_addr,
  input  logic [15:0]        dead_data,
  output logic [15:0]        sample_out,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic [1:0]         active,
  output logic [7:0]         overrun_cnt
);
  localparam int PW = DEAD_AW + 1;
  localparam logic [1:0] A_IDLE = 2'b00, A_JUMP = 2'b01, A_DEAD = 2'b10;
  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, HOLD} state_t;
  state_t state;
  logic pend_jump, pend_dead, overrun, frame, want_jump, want_dead, at_end;
  logic [PW-1:0] ptr;
  logic [15:0] rom_data;
  always_comb begin
    overrun = sample_tick && ((sample_valid && !sample_ready) || state == FETCH || state == CAPTURE);
    frame = sample_tick && !overrun && !stop;
    want_dead = pend_dead || play_dead;
    want_jump = pend_jump || (play_jump && active != A_DEAD);
    at_end = ptr == (active == A_DEAD ? PW'(DEAD_LEN) : PW'(JUMP_LEN));
    rom_data = active == A_DEAD ? dead_data : jump_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      pend_jump <= 1'b0;
      pend_dead <= 1'b0;
      ptr <= '0;
      jump_addr <= '0;
      dead_addr <= '0;
      sample_out <= '0;
      sample_valid <= 1'b0;
      active <= A_IDLE;
      overrun_cnt <= '0;
    end else begin
      if (sample_valid && sample_ready) sample_valid <= 1'b0;
      if (overrun && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 8'd1;
      if (stop) begin
        state <= IDLE;
        pend_jump <= 1'b0;
        pend_dead <= 1'b0;
        ptr <= '0;
        jump_addr <= '0;
        dead_addr <= '0;
        active <= A_IDLE;
      end else if (frame) begin
        pend_jump <= 1'b0;
        pend_dead <= 1'b0;
        if (want_dead || want_jump) begin
          active <= want_dead ? A_DEAD : A_JUMP;
          ptr <= '0;
          jump_addr <= '0;
          dead_addr <= '0;
          state <= FETCH;
        end else if (state == HOLD && !at_end) begin
          jump_addr <= active == A_JUMP ? ptr[JUMP_AW-1:0] : '0;
          dead_addr <= active == A_DEAD ? ptr[DEAD_AW-1:0] : '0;
          state <= FETCH;
        end else begin
          // no effect to play: emit silence so every frame still gets a sample
          active <= A_IDLE;
          ptr <= '0;
          jump_addr <= '0;
          dead_addr <= '0;
          sample_out <= '0;
          sample_valid <= 1'b1;
          state <= IDLE;
        end
      end else begin
        pend_jump <= want_jump;
        pend_dead <= want_dead;
        if (state == FETCH) state <= CAPTURE;
        else if (state == CAPTURE) begin
          sample_out <= $signed(rom_data) >>> volume;
          sample_valid <= 1'b1;
          ptr <= ptr + PW'(1);
          state <= HOLD;
        end
      end
    end
  end
endmodule
